generic_fifo_rd_drain: RTL and testbench

- Read-side consumer for the dual-clock FIFO/RAM envelopes (rd_clk domain).
- Pops entries from the FIFO read port and absorbs the compiled RAM's fixed read latency.
- Presents the data as a valid/ready stream with full throughput.
- Supports a discard-all flush and keeps drain statistics and sticky error status.

---
 rtl/generic_fifo_rd_drain_pkg.sv | 14 +
 rtl/generic_fifo_rd_drain_obuf.sv | 69 ++++++
 rtl/generic_fifo_rd_drain.sv | 139 +++++++++++++
 tb/tb_generic_fifo_rd_drain.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_fifo_rd_drain_pkg.sv
// Shared types and limits for the FIFO read-side drain block.
package generic_fifo_rd_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Supported range of the RAM read latency.
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

endpackage

// File: rtl/generic_fifo_rd_drain_obuf.sv
// Circular output buffer: DEPTH x DAT_WIDTH, push/pop/clear, occupancy out.
// Ports: clk_i, rst_ni, clr_i, push_i, push_data_i, pop_i,
//        head_data_o, occ_o, ovf_o (push dropped because buffer full).
module generic_fifo_rd_drain_obuf #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DAT_WIDTH = 36
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [DAT_WIDTH-1:0]         push_data_i,
  input  logic                         pop_i,
  output logic [DAT_WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o,
  output logic                         ovf_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DAT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]        occ_q;
  logic                 full, do_pop, do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (occ_q == OW'(DEPTH));
  assign do_pop  = pop_i & (occ_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full buffer is
  // only dropped when nothing leaves.
  assign do_push = push_i & (~full | do_pop);
  assign ovf_o   = push_i & full & ~do_pop & ~clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        occ_q <= occ_q + OW'(1);
      end else if (do_pop && !do_push) begin
        occ_q <= occ_q - OW'(1);
      end
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/generic_fifo_rd_drain.sv
// FIFO read-side drain: pops the FIFO, absorbs RAM read latency, and presents
// a valid/ready stream with flush, word counter and sticky error.
// Ports: clk, reset_n, enable, fifo_rd_op, fifo_rd_data, fifo_rd_empty,
//        fifo_rd_empty_err, out_valid, out_data, out_ready, flush_req,
//        flush_busy, flush_done, word_cnt, err_sticky, err_clr.
module generic_fifo_rd_drain
  import generic_fifo_rd_drain_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = 36,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic                 fifo_rd_op,
  input  logic [DAT_WIDTH-1:0] fifo_rd_data,
  input  logic                 fifo_rd_empty,
  input  logic                 fifo_rd_empty_err,
  output logic                 out_valid,
  output logic [DAT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  localparam int unsigned OW = $clog2(OUT_DEPTH + 1);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || OUT_DEPTH < RD_LAT + 1) begin : g_param_err
    $error("generic_fifo_rd_drain: unsupported RD_LAT/OUT_DEPTH combination");
  end

  state_e               state_q, state_d;
  logic [RD_LAT-1:0]    vld_q;
  logic [CNT_WIDTH-1:0] word_cnt_q;
  logic                 err_q;

  logic [OW-1:0]        occ;
  logic                 ovf, buf_clr, push, accept, credit_ok;
  logic [7:0]           inflight_n;

  // Outstanding reads: anything still travelling through the RAM latency.
  always_comb begin
    inflight_n = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight_n = inflight_n + 8'(vld_q[i]);
    end
  end

  assign accept    = out_valid & out_ready;
  // credit = OUT_DEPTH - occ - inflight + accept >= 1, kept non-negative.
  assign credit_ok = (8'(occ) + inflight_n) < (8'(OUT_DEPTH) + 8'(accept));

  assign fifo_rd_op = ~fifo_rd_empty &
                      (((state_q == RUN) & enable & credit_ok) | (state_q == FLUSH));

  always_comb begin
    state_d    = state_q;
    buf_clr    = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          buf_clr = 1'b1;
        end else if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush_req) begin
          state_d = FLUSH;
          buf_clr = 1'b1;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (fifo_rd_empty && (vld_q == '0)) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Words landing during FLUSH are discarded rather than buffered.
  assign push = vld_q[RD_LAT-1] & (state_q != FLUSH);

  generic_fifo_rd_drain_obuf #(
    .DEPTH     (OUT_DEPTH),
    .DAT_WIDTH (DAT_WIDTH)
  ) u_obuf (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .clr_i       (buf_clr),
    .push_i      (push),
    .push_data_i (fifo_rd_data),
    .pop_i       (accept),
    .head_data_o (out_data),
    .occ_o       (occ),
    .ovf_o       (ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q[0] <= fifo_rd_op;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      if (accept) begin
        word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
      end
      if (fifo_rd_empty_err || ovf) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign out_valid  = (occ != '0) & (state_q != FLUSH);
  assign flush_busy = (state_q == FLUSH);
  assign word_cnt   = word_cnt_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_generic_fifo_rd_drain.sv
module tb_generic_fifo_rd_drain;

  localparam int unsigned DW = 36;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_rd_op;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty = 1'b1;
  logic          fifo_rd_empty_err = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          flush_req = 1'b0;
  logic          flush_busy;
  logic          flush_done;
  logic [CW-1:0] word_cnt;
  logic          err_sticky;
  logic          err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  generic_fifo_rd_drain #(
    .DAT_WIDTH (DW),
    .RD_LAT    (1),
    .OUT_DEPTH (2),
    .CNT_WIDTH (CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .fifo_rd_op        (fifo_rd_op),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_rd_empty     (fifo_rd_empty),
    .fifo_rd_empty_err (fifo_rd_empty_err),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ready         (out_ready),
    .flush_req         (flush_req),
    .flush_busy        (flush_busy),
    .flush_done        (flush_done),
    .word_cnt          (word_cnt),
    .err_sticky        (err_sticky),
    .err_clr           (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO + RAM model, RD_LAT=1: data one cycle after the pop, empty registered.
  logic [DW-1:0] mdl[$];
  always @(posedge clk) begin
    if (fifo_rd_op && mdl.size() != 0) fifo_rd_data <= mdl.pop_front();
    fifo_rd_empty <= (mdl.size() == 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and stream monitor.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  logic [CW-1:0] exp_wcnt = '0;
  int pop_cyc[$];
  int acc_cyc[$];
  int pops = 0, accs = 0, out_cnt = 0, max_out = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_rd_op) begin
        pop_cyc.push_back(cyc);
        pops++;
        out_cnt++;
      end
      if (out_valid && out_ready) begin
        acc_cyc.push_back(cyc);
        accs++;
        out_cnt--;
        exp_wcnt = exp_wcnt + 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_word: got 0x%0h expected none", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("sb_data", out_data, exp_w);
        end
      end
      if (out_cnt > max_out) max_out = out_cnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      mdl.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
  endtask

  typedef struct {
    logic  err;
    logic  clr;
    logic  exp;
    string name;
  } err_vec_t;
  err_vec_t tbl[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    int acc0, pop0, n, done_cnt;
    logic done_empty;

    tbl[0] = '{1'b0, 1'b0, 1'b0, "err_idle"};
    tbl[1] = '{1'b1, 1'b0, 1'b1, "err_set"};
    tbl[2] = '{1'b0, 1'b0, 1'b1, "err_hold"};
    tbl[3] = '{1'b0, 1'b1, 1'b0, "err_clr"};
    tbl[4] = '{1'b1, 1'b1, 1'b1, "err_set_wins"};
    tbl[5] = '{1'b0, 1'b0, 1'b1, "err_hold2"};
    tbl[6] = '{1'b0, 1'b1, 1'b0, "err_clr2"};
    tbl[7] = '{1'b0, 1'b0, 1'b0, "err_stay_clr"};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_op", fifo_rd_op, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_done", flush_done, 0);
    check("rst_wcnt", word_cnt, 0);
    check("rst_err", err_sticky, 0);
    reset_n = 1'b1;
    step();

    // 1: throughput
    pop_cyc.delete();
    acc_cyc.delete();
    load(8, 36'h0);
    step();
    out_ready = 1'b1;
    enable = 1'b1;
    drain("t1_drain", 100);
    check("t1_pop_count", pop_cyc.size(), 8);
    check("t1_pop_consec", pop_cyc[7] - pop_cyc[0], 7);
    check("t1_first_out", acc_cyc[0] - pop_cyc[0], 2);
    check("t1_out_consec", acc_cyc[7] - acc_cyc[0], 7);
    check("t1_wcnt", word_cnt, 8);

    // 2: backpressure 1,0,0,1
    out_cnt = 0;
    max_out = 0;
    acc0 = accs;
    pat = 4'b1001;
    load(8, 36'h20);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      out_ready = pat[i % 4];
      step();
    end
    out_ready = 1'b1;
    check("t2_drain", exp_q.size(), 0);
    check("t2_count", accs - acc0, 8);
    check("t2_outstanding_le2", (max_out <= 2), 1);
    check("t2_wcnt", word_cnt, exp_wcnt);
    check("t2_err", err_sticky, 0);

    // 3: flush with buffer full
    out_ready = 1'b0;
    load(5, 36'h30);
    repeat (6) step();
    check("t3_pre_valid", out_valid, 1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    exp_q.delete();
    check("t3_valid_drop", out_valid, 0);
    check("t3_busy", flush_busy, 1);
    done_cnt = 0;
    done_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (flush_done) begin
        done_cnt++;
        done_empty = fifo_rd_empty;
      end
      step();
    end
    check("t3_done_once", done_cnt, 1);
    check("t3_done_empty", done_empty, 1);
    check("t3_fifo_popped", mdl.size(), 0);
    check("t3_busy_end", flush_busy, 0);
    check("t3_wcnt", word_cnt, exp_wcnt);

    // 4: enable off with one read in flight
    enable = 1'b0;
    out_ready = 1'b1;
    load(3, 36'h40);
    step();
    enable = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fifo_rd_op) break;
    end
    check("t4_first_pop", fifo_rd_op, 1);
    step();
    enable = 1'b0;
    pop0 = pops;
    acc0 = accs;
    repeat (6) step();
    check("t4_no_more_pops", pops - pop0, 0);
    check("t4_inflight_out", accs - acc0, 1);
    check("t4_left", exp_q.size(), 2);
    enable = 1'b1;
    drain("t4_drain", 50);

    // 6a: sticky error table
    for (int i = 0; i < 8; i++) begin
      fifo_rd_empty_err = tbl[i].err;
      err_clr = tbl[i].clr;
      step();
      check(tbl[i].name, err_sticky, tbl[i].exp);
    end
    fifo_rd_empty_err = 1'b0;
    err_clr = 1'b0;

    // 5: reset with inflight=1, occ=1
    fifo_rd_empty_err = 1'b1;
    step();
    fifo_rd_empty_err = 1'b0;
    out_ready = 1'b0;
    load(4, 36'h50);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fifo_rd_op) break;
    end
    check("t5_first_pop", fifo_rd_op, 1);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("t5_rd_op", fifo_rd_op, 0);
    check("t5_valid", out_valid, 0);
    check("t5_data", out_data, 0);
    check("t5_busy", flush_busy, 0);
    check("t5_done", flush_done, 0);
    check("t5_wcnt", word_cnt, 0);
    check("t5_err", err_sticky, 0);
    exp_q = mdl;
    exp_wcnt = '0;
    step();
    step();
    reset_n = 1'b1;
    acc0 = accs;
    step();
    check("t5_post_valid", out_valid, 0);
    out_ready = 1'b1;
    drain("t5_drain", 50);
    check("t5_count", accs - acc0, 2);

    // 6b: counter wrap, 17 words since reset
    load(15, 36'h60);
    drain("t6_drain", 100);
    check("t6_count", accs - acc0, 17);
    check("t6_wcnt_wrap", word_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
